sm_addsub_seq: RTL and testbench
================================

# sm_addsub_seq

Parametrised sequential signed adder/subtractor for two N-bit two's-complement operands, computed internally in sign-magnitude form by a multi-cycle control unit + datapath pair. Next generation of the fixed-width 5-bit add-only unit: adds width parameter N, an add/subtract mode, a start/busy/done handshake, and an overflow flag with optional saturation. Sits behind any register-file or testbench driver that presents operands plus a start pulse.

## Interface
- N, default 5: operand and result width in bits (N ≥ 2).
- clk  in  1  rising-edge clock.
- RESET_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- op  in  1  0 = a + b, 1 = a − b.
- a  in  N  operand A, two's complement.
- b  in  N  operand B, two's complement.
- result  out  N  two's-complement result, held until the next accepted start.
- ovf  out  1  exact result outside [−2^(N−1), 2^(N−1)−1]; held with result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: result/ovf valid.

## Operation
- States: IDLE → MAG → COMP → ADDSUB → STORE → DONE → IDLE.
- IDLE: on start=1 at edge, register a, b, op; go to MAG. start=0: stay.
- MAG: sA = a[N−1], magA = |a| as N-bit unsigned (−2^(N−1) → 2^(N−1), no loss); same for B; effective sign sBe = sB XOR op.
- COMP: register signs_eq = (sA == sBe), a_ge = (magA ≥ magB).
- ADDSUB: signs_eq → mag = magA + magB (N+1 bits), sign = sA. Else larger − smaller, sign of the larger; equal magnitudes → mag 0, sign 0 (no negative zero).
- STORE: exact = sign ? −mag : mag, N+1-bit two's complement; ovf = exact not representable in N bits; result per Configuration.
- DONE: done=1 one cycle, then IDLE unconditionally.
- start outside IDLE (including DONE) ignored; operand inputs ignored outside the accepting edge.

## Timing
- Reset (async assert, any state): state=IDLE, result=0, ovf=0, busy=0, done=0, internal regs 0. Deassertion synchronous to clk by the driving environment.
- Start accepted at edge e0; result/ovf update at e4; done high between e4 and e5; busy high from e0 to e5.
- Latency 5 cycles start-to-done; minimum start-to-start spacing 6 cycles (next start accepted at e6 earliest).
- done and busy are Moore outputs decoded from registered state, glitch-free.
- Reset mid-operation aborts; no done pulse for the aborted request.

## Configuration
- SM_ADDSUB_SAT_EN defined: on ovf=1, result clamps to 2^(N−1)−1 if sign=0, −2^(N−1) if sign=1.
- Undefined: on ovf=1, result = exact[N−1:0] (wrap). ovf flag identical in both builds.

## Structure
- Package sm_addsub_pkg: FSM state enum, OP_ADD/OP_SUB constants.
- Sub-module sm_addsub_uc: control FSM emitting per-state enables (load_ab, load_mag, comp, add_sub, load_res, done); top sm_addsub_seq holds the datapath registers and arithmetic.

## Test plan
- N=5, a=3, b=−8, op=0 → result=11011 (−5), ovf=0, done at start+5.
- a=15, b=1, op=0 → ovf=1; wrap build result=10000, SAT build 01111.
- a=−16, b=1, op=1 → ovf=1; wrap result=01111, SAT 10000; a=−16, b=−16, op=0 → wrap 00000, SAT 10000.
- a=5, b=5, op=1 → result=00000, ovf=0; a=−16, b=−16, op=1 → 00000.
- start held high throughout → requests accepted only every 6 cycles; operand change mid-op has no effect on the result in flight.
- RESET_n low during ADDSUB → result=0, busy=0, done never pulses; next start completes normally.

Source files
------------

// File: rtl/sm_addsub_pkg.sv
// Shared types and constants for the sequential sign-magnitude adder/subtractor.
package sm_addsub_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAG,
    S_COMP,
    S_ADDSUB,
    S_STORE,
    S_DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/sm_addsub_uc.sv
// Control FSM: walks IDLE->MAG->COMP->ADDSUB->STORE->DONE and emits one datapath
// enable per state; busy/done are Moore outputs decoded from the state register.
module sm_addsub_uc
  import sm_addsub_pkg::*;
(
  input  logic clk,
  input  logic RESET_n,
  input  logic start,
  output logic load_ab,
  output logic load_mag,
  output logic comp,
  output logic add_sub,
  output logic load_res,
  output logic done,
  output logic busy
);

  state_t state_q, state_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_MAG;
      S_MAG:    state_d = S_COMP;
      S_COMP:   state_d = S_ADDSUB;
      S_ADDSUB: state_d = S_STORE;
      S_STORE:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_ab  = (state_q == S_IDLE) && start;
    load_mag = (state_q == S_MAG);
    comp     = (state_q == S_COMP);
    add_sub  = (state_q == S_ADDSUB);
    load_res = (state_q == S_STORE);
    done     = (state_q == S_DONE);
    busy     = (state_q != S_IDLE);
  end

endmodule

// File: rtl/sm_addsub_seq.sv
// Sequential N-bit signed add/subtract via sign-magnitude datapath.
// Define SM_ADDSUB_SAT_EN to saturate the result on overflow instead of wrapping.
module sm_addsub_seq
  import sm_addsub_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         RESET_n,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  localparam logic [N:0]   HALF    = {1'b0, 1'b1, {(N-1){1'b0}}};
  localparam logic [N:0]   HALF_M1 = {2'b00, {(N-1){1'b1}}};
  localparam logic [N-1:0] POS_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] NEG_MIN = {1'b1, {(N-1){1'b0}}};

  logic load_ab, load_mag, comp, add_sub, load_res;

  sm_addsub_uc u_uc (
    .clk      (clk),
    .RESET_n  (RESET_n),
    .start    (start),
    .load_ab  (load_ab),
    .load_mag (load_mag),
    .comp     (comp),
    .add_sub  (add_sub),
    .load_res (load_res),
    .done     (done),
    .busy     (busy)
  );

  logic [N-1:0] a_q, b_q, mag_a, mag_b;
  logic         op_q, sign_a, sign_b, signs_eq, a_ge, sign_r;
  logic [N:0]   mag_r;

  // ADDSUB stage: combine magnitudes; equal magnitudes of opposite sign give +0.
  logic [N:0]   sum_w, diff_w, mag_w;
  logic         sign_w;
  always_comb begin
    sum_w  = {1'b0, mag_a} + {1'b0, mag_b};
    diff_w = a_ge ? {1'b0, mag_a - mag_b} : {1'b0, mag_b - mag_a};
    mag_w  = signs_eq ? sum_w : diff_w;
    if (signs_eq)          sign_w = sign_a;
    else if (diff_w == '0) sign_w = 1'b0;
    else                   sign_w = a_ge ? sign_a : sign_b;
  end

  // STORE stage: overflow judged on the magnitude so the N+1-bit exact value
  // never has to be materialised; the low N bits are the wrapped result.
  logic [N-1:0] exact_lo, res_w;
  logic         ovf_w;
  always_comb begin
    exact_lo = sign_r ? -mag_r[N-1:0] : mag_r[N-1:0];
    ovf_w    = sign_r ? (mag_r > HALF) : (mag_r > HALF_M1);
`ifdef SM_ADDSUB_SAT_EN
    res_w    = ovf_w ? (sign_r ? NEG_MIN : POS_MAX) : exact_lo;
`else
    res_w    = exact_lo;
`endif
  end

  // NOTE: all datapath registers are reset so an aborted request leaves no
  // stale operands or result behind.
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      signs_eq <= 1'b0;
      a_ge     <= 1'b0;
      mag_r    <= '0;
      sign_r   <= 1'b0;
      result   <= '0;
      ovf      <= 1'b0;
    end else begin
      if (load_ab) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
      if (load_mag) begin
        sign_a <= a_q[N-1];
        sign_b <= b_q[N-1] ^ (op_q == OP_SUB);
        mag_a  <= a_q[N-1] ? -a_q : a_q;
        mag_b  <= b_q[N-1] ? -b_q : b_q;
      end
      if (comp) begin
        signs_eq <= (sign_a == sign_b);
        a_ge     <= (mag_a >= mag_b);
      end
      if (add_sub) begin
        mag_r  <= mag_w;
        sign_r <= sign_w;
      end
      if (load_res) begin
        result <= res_w;
        ovf    <= ovf_w;
      end
    end
  end

endmodule

// File: tb/tb_sm_addsub_seq.sv
// Scoreboard bench for sm_addsub_seq: integer reference model, decoupled monitor.
module tb_sm_addsub_seq;

  localparam int N = 5;

  typedef struct {
    logic [N-1:0] res;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] result;
  logic         ovf, busy, done;

  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   cooldown = 0;
  exp_t sb[$];

  sm_addsub_seq #(.N(N)) dut (
    .clk     (clk),
    .RESET_n (rst_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .result  (result),
    .ovf     (ovf),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Exact integer arithmetic, then range check and wrap/clamp.
  function automatic exp_t ref_model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                     input logic opv, input int c);
    exp_t r;
    int sa, sbv, ex, hi, lo;
    sa  = int'($signed(av));
    sbv = int'($signed(bv));
    ex  = opv ? sa - sbv : sa + sbv;
    hi  = (1 << (N - 1)) - 1;
    lo  = -(1 << (N - 1));
    r.ovf = (ex > hi) || (ex < lo);
`ifdef SM_ADDSUB_SAT_EN
    r.res = r.ovf ? ((ex > hi) ? N'(hi) : N'(lo)) : N'(ex);
`else
    r.res = N'(ex);
`endif
    r.cyc = c;
    return r;
  endfunction

  // Acceptance model: a start is taken when not busy; busy spans 5 further edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cooldown <= 0;
      sb.delete();
    end else begin
      cyc <= cyc + 1;
      if (cooldown != 0) cooldown <= cooldown - 1;
      else if (start) begin
        sb.push_back(ref_model(a, b, op, cyc + 5));
        cooldown <= 5;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy", int'(busy), int'(cooldown != 0));
      if (done) begin
        if (sb.size() == 0) check("spurious_done", int'(done), 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("result", int'(result), int'(e.res));
          check("ovf", int'(ovf), int'(e.ovf));
          check("latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv, input logic opv);
    @(posedge clk); #1;
    a = av; b = bv; op = opv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_result"}, int'(result), 0);
    check({name, "_ovf"},    int'(ovf), 0);
    check({name, "_busy"},   int'(busy), 0);
    check({name, "_done"},   int'(done), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;

    send(5'd3,  5'b11000, 1'b0);   //  3 + -8
    send(5'd15, 5'd1,     1'b0);   // 15 + 1
    send(5'b10000, 5'd1,  1'b1);   // -16 - 1
    send(5'b10000, 5'b10000, 1'b0);
    send(5'd5,  5'd5,     1'b1);
    send(5'b10000, 5'b10000, 1'b1);
    send(5'd15, 5'b10000, 1'b1);   // 15 - -16
    send(5'b11111, 5'd1,  1'b0);   // -1 + 1

    // start held high with operands churning every cycle
    @(posedge clk); #1;
    start = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      a = N'($urandom); b = N'($urandom); op = 1'($urandom);
    end
    start = 1'b0;
    repeat (8) @(posedge clk);

    // reset while the request sits in ADDSUB
    @(posedge clk); #1;
    a = 5'd7; b = 5'd9; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("abort_hold");
    rst_n = 1'b1;
    send(5'd7, 5'd9, 1'b0);

    // random start pattern and operands
    repeat (300) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      a = N'($urandom); b = N'($urandom); op = 1'($urandom);
    end
    start = 1'b0;
    repeat (10) @(posedge clk);

    #1 check("drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
